// File: rtl/call_blink_pkg.sv
// Shared types and default constants for the call-indicator blink controller.
package call_blink_pkg;

  localparam int unsigned BLINKS_DEF  = 3;
  localparam int unsigned PEND_W_DEF  = 2;
  localparam int unsigned BLINK_CNT_W = 4;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t ON   = 2'd1;
  localparam state_t OFF  = 2'd2;

endpackage

// File: rtl/call_blink_ctrl_if.sv
// Desk/timer/display signal bundle for call_blink_ctrl.
interface call_blink_ctrl_if
  import call_blink_pkg::*;
#(
  parameter int unsigned PEND_W = PEND_W_DEF
);

  logic              call;
  logic              timer_done;
  logic              timer_start;
  logic              blink_on;
  logic              busy;
  logic [PEND_W-1:0] pend_cnt;
  logic              overflow;

  // Environment side: desk call source and external half-second timer.
  modport master (
    output call, timer_done,
    input  timer_start, blink_on, busy, pend_cnt, overflow
  );

  // Controller side.
  modport slave (
    input  call, timer_done,
    output timer_start, blink_on, busy, pend_cnt, overflow
  );

endinterface

// File: rtl/call_blink_ctrl_pend_counter.sv
// Saturating up/down counter of queued calls; sat_drop pulses the cycle after
// an increment is lost to saturation.
module pend_counter #(
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         sat_drop
);

  localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

  logic [W-1:0] count_q, count_d;
  logic         sat_q, sat_d;

  // Simultaneous inc and dec cancel out and never count as a drop.
  always_comb begin
    count_d = count_q;
    sat_d   = 1'b0;
    if (clr) begin
      count_d = '0;
    end else if (inc && !dec) begin
      if (count_q == CNT_MAX) begin
        sat_d = 1'b1;
      end else begin
        count_d = count_q + W'(1);
      end
    end else if (dec && !inc && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      sat_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      sat_q   <= sat_d;
    end
  end

  assign count    = count_q;
  assign sat_drop = sat_q;

endmodule

// File: rtl/call_blink_ctrl.sv
// Queue-desk call indicator: flashes BLINKS on/off phases per call, queueing
// calls that arrive mid-sequence. Optional cancel input: CALL_BLINK_CANCEL_EN.
module call_blink_ctrl
  import call_blink_pkg::*;
#(
  parameter int unsigned BLINKS = BLINKS_DEF,
  parameter int unsigned PEND_W = PEND_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
`ifdef CALL_BLINK_CANCEL_EN
  input  logic             cancel,
`endif
  call_blink_ctrl_if.slave bus
);

  state_t                 state_q, state_d;
  logic [BLINK_CNT_W-1:0] cnt_q, cnt_d;
  logic [BLINK_CNT_W-1:0] cnt_inc;
  logic                   ts_q, ts_d;
  logic                   blink_q, blink_d;
  logic                   busy_q, busy_d;
  logic                   pend_inc, pend_dec, pend_clr;
  logic                   pend_nz, done_v;
  logic [PEND_W-1:0]      pend_q;
  logic                   ovf_q;

  assign pend_nz = (pend_q != '0);
  // Timer completions are only honoured once a phase has launched its wait.
  assign done_v  = bus.timer_done && !ts_q;
  assign cnt_inc = cnt_q + BLINK_CNT_W'(1);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ts_d     = 1'b0;
    pend_inc = 1'b0;
    pend_dec = 1'b0;
    pend_clr = 1'b0;
    case (state_q)
      IDLE: begin
        pend_inc = bus.call && pend_nz;
        if (bus.call || pend_nz) begin
          state_d  = ON;
          cnt_d    = '0;
          ts_d     = 1'b1;
          pend_dec = pend_nz;
        end
      end
      ON: begin
        pend_inc = bus.call;
        if (done_v) begin
          state_d = OFF;
          ts_d    = 1'b1;
        end
      end
      OFF: begin
        pend_inc = bus.call;
        if (done_v) begin
          if (cnt_inc == BLINK_CNT_W'(BLINKS)) begin
            cnt_d = '0;
            // Chain straight into the next queued call without an IDLE cycle.
            if (pend_nz) begin
              state_d  = ON;
              ts_d     = 1'b1;
              pend_dec = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end else begin
            cnt_d   = cnt_inc;
            state_d = ON;
            ts_d    = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
`ifdef CALL_BLINK_CANCEL_EN
    if (cancel) begin
      state_d  = IDLE;
      cnt_d    = '0;
      ts_d     = 1'b0;
      pend_inc = 1'b0;
      pend_dec = 1'b0;
      pend_clr = 1'b1;
    end
`endif
    blink_d = (state_d == ON);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ts_q    <= 1'b0;
      blink_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ts_q    <= ts_d;
      blink_q <= blink_d;
      busy_q  <= busy_d;
    end
  end

  pend_counter #(
    .W (PEND_W)
  ) u_pend (
    .clk      (clk),
    .rst      (rst),
    .clr      (pend_clr),
    .inc      (pend_inc),
    .dec      (pend_dec),
    .count    (pend_q),
    .sat_drop (ovf_q)
  );

  assign bus.timer_start = ts_q;
  assign bus.blink_on    = blink_q;
  assign bus.busy        = busy_q;
  assign bus.pend_cnt    = pend_q;
  assign bus.overflow    = ovf_q;

endmodule

// File: tb/tb_call_blink_ctrl.sv
// Directed bench for call_blink_ctrl with a 4-cycle timer model (BLINKS=3, PEND_W=2).
module tb_call_blink_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
`ifdef CALL_BLINK_CANCEL_EN
  logic cancel = 1'b0;
`endif
  logic       td_force = 1'b0;
  logic [3:0] sr = 4'b0;
  int         n_vec = 0;
  int         n_err = 0;

  call_blink_ctrl_if #(.PEND_W(2)) bus ();

  call_blink_ctrl #(.BLINKS(3), .PEND_W(2)) dut (
    .clk    (clk),
    .rst    (rst),
`ifdef CALL_BLINK_CANCEL_EN
    .cancel (cancel),
`endif
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Timer: timer_done is high 4 cycles after the cycle timer_start was high.
  always @(posedge clk) sr <= {sr[2:0], bus.timer_start};
  assign bus.timer_done = sr[3] | td_force;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle;
    int k;
    k = 0;
    while (bus.busy === 1'b1 && k < 300) begin
      tick();
      k++;
    end
    n_vec++;
    if (bus.busy !== 1'b0) begin
      n_err++; $display("FAIL wait_idle: busy=%b after %0d cycles, want 0", bus.busy, k);
    end
    repeat (6) tick();
  endtask

  task automatic test_reset;
    bus.call = 1'b0;
    rst = 1'b1;
    repeat (6) tick();
    n_vec++; if (bus.timer_start !== 1'b0) begin n_err++; $display("FAIL reset_ts: got %b want 0", bus.timer_start); end
    n_vec++; if (bus.blink_on !== 1'b0) begin n_err++; $display("FAIL reset_blink: got %b want 0", bus.blink_on); end
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_vec++; if (bus.pend_cnt !== 2'd0) begin n_err++; $display("FAIL reset_pend: got %0d want 0", bus.pend_cnt); end
    n_vec++; if (bus.overflow !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b want 0", bus.overflow); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_idle_done;
    td_force = 1'b1;
    tick();
    td_force = 1'b0;
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL idle_done_busy: got %b want 0", bus.busy); end
    n_vec++; if (bus.timer_start !== 1'b0) begin n_err++; $display("FAIL idle_done_ts: got %b want 0", bus.timer_start); end
    tick();
    n_vec++; if (bus.blink_on !== 1'b0) begin n_err++; $display("FAIL idle_done_blink: got %b want 0", bus.blink_on); end
    n_vec++; if (bus.timer_start !== 1'b0) begin n_err++; $display("FAIL idle_done_ts2: got %b want 0", bus.timer_start); end
  endtask

  task automatic test_single;
    int ts_cnt, on_cnt, busy_cnt, pend_nz, ovf_cnt;
    ts_cnt = 0; on_cnt = 0; busy_cnt = 0; pend_nz = 0; ovf_cnt = 0;
    bus.call = 1'b1;
    tick();
    bus.call = 1'b0;
    n_vec++; if (bus.timer_start !== 1'b1) begin n_err++; $display("FAIL single_first_ts: got %b want 1", bus.timer_start); end
    n_vec++; if (bus.blink_on !== 1'b1) begin n_err++; $display("FAIL single_first_blink: got %b want 1", bus.blink_on); end
    for (int i = 0; i < 40; i++) begin
      ts_cnt += int'(bus.timer_start);
      on_cnt += int'(bus.blink_on);
      busy_cnt += int'(bus.busy);
      ovf_cnt += int'(bus.overflow);
      if (bus.pend_cnt !== 2'd0) pend_nz++;
      tick();
    end
    n_vec++; if (ts_cnt != 6) begin n_err++; $display("FAIL single_ts_count: got %0d want 6", ts_cnt); end
    n_vec++; if (on_cnt != 15) begin n_err++; $display("FAIL single_on_cycles: got %0d want 15", on_cnt); end
    n_vec++; if (busy_cnt != 30) begin n_err++; $display("FAIL single_busy_cycles: got %0d want 30", busy_cnt); end
    n_vec++; if (pend_nz != 0) begin n_err++; $display("FAIL single_pend: got %0d nonzero cycles want 0", pend_nz); end
    n_vec++; if (ovf_cnt != 0) begin n_err++; $display("FAIL single_ovf: got %0d want 0", ovf_cnt); end
    wait_idle();
  endtask

  task automatic test_overflow;
    int ts_cnt, busy_cnt, ovf_cnt;
    ts_cnt = 0; busy_cnt = 0; ovf_cnt = 0;
    bus.call = 1'b1;
    repeat (4) tick();
    n_vec++; if (bus.pend_cnt !== 2'd3) begin n_err++; $display("FAIL ovf_pend3: got %0d want 3", bus.pend_cnt); end
    n_vec++; if (bus.overflow !== 1'b0) begin n_err++; $display("FAIL ovf_early: got %b want 0", bus.overflow); end
    tick();
    bus.call = 1'b0;
    n_vec++; if (bus.overflow !== 1'b1) begin n_err++; $display("FAIL ovf_pulse: got %b want 1", bus.overflow); end
    n_vec++; if (bus.pend_cnt !== 2'd3) begin n_err++; $display("FAIL ovf_pend_hold: got %0d want 3", bus.pend_cnt); end
    tick();
    n_vec++; if (bus.overflow !== 1'b0) begin n_err++; $display("FAIL ovf_single_pulse: got %b want 0", bus.overflow); end
    for (int i = 0; i < 130; i++) begin
      if (i == 25) begin
        n_vec++; if (bus.pend_cnt !== 2'd2 || bus.timer_start !== 1'b1) begin
          n_err++; $display("FAIL ovf_seq2_start: pend=%0d ts=%b want pend=2 ts=1", bus.pend_cnt, bus.timer_start); end
      end
      if (i == 55) begin
        n_vec++; if (bus.pend_cnt !== 2'd1 || bus.blink_on !== 1'b1) begin
          n_err++; $display("FAIL ovf_seq3_start: pend=%0d blink=%b want pend=1 blink=1", bus.pend_cnt, bus.blink_on); end
      end
      if (i == 85) begin
        n_vec++; if (bus.pend_cnt !== 2'd0 || bus.timer_start !== 1'b1) begin
          n_err++; $display("FAIL ovf_seq4_start: pend=%0d ts=%b want pend=0 ts=1", bus.pend_cnt, bus.timer_start); end
      end
      ts_cnt += int'(bus.timer_start);
      busy_cnt += int'(bus.busy);
      ovf_cnt += int'(bus.overflow);
      tick();
    end
    n_vec++; if (busy_cnt != 115) begin n_err++; $display("FAIL ovf_busy_cycles: got %0d want 115", busy_cnt); end
    n_vec++; if (ts_cnt != 23) begin n_err++; $display("FAIL ovf_ts_count: got %0d want 23", ts_cnt); end
    n_vec++; if (ovf_cnt != 0) begin n_err++; $display("FAIL ovf_extra: got %0d want 0", ovf_cnt); end
    wait_idle();
  endtask

  task automatic test_back_to_back;
    int busy_cnt;
    busy_cnt = 0;
    bus.call = 1'b1;
    repeat (2) tick();
    bus.call = 1'b0;
    n_vec++; if (bus.pend_cnt !== 2'd1) begin n_err++; $display("FAIL b2b_pend1: got %0d want 1", bus.pend_cnt); end
    repeat (28) tick();
    n_vec++; if (bus.busy !== 1'b1 || bus.blink_on !== 1'b0) begin
      n_err++; $display("FAIL b2b_last_off: busy=%b blink=%b want busy=1 blink=0", bus.busy, bus.blink_on); end
    bus.call = 1'b1;
    tick();
    bus.call = 1'b0;
    n_vec++; if (bus.pend_cnt !== 2'd1) begin n_err++; $display("FAIL b2b_pend_hold: got %0d want 1", bus.pend_cnt); end
    n_vec++; if (bus.timer_start !== 1'b1 || bus.blink_on !== 1'b1) begin
      n_err++; $display("FAIL b2b_restart: ts=%b blink=%b want ts=1 blink=1", bus.timer_start, bus.blink_on); end
    n_vec++; if (bus.overflow !== 1'b0) begin n_err++; $display("FAIL b2b_ovf: got %b want 0", bus.overflow); end
    for (int i = 0; i < 70; i++) begin
      if (i == 30) begin
        n_vec++; if (bus.pend_cnt !== 2'd0 || bus.timer_start !== 1'b1) begin
          n_err++; $display("FAIL b2b_seq3: pend=%0d ts=%b want pend=0 ts=1", bus.pend_cnt, bus.timer_start); end
      end
      busy_cnt += int'(bus.busy);
      tick();
    end
    n_vec++; if (busy_cnt != 60) begin n_err++; $display("FAIL b2b_busy_cycles: got %0d want 60", busy_cnt); end
    wait_idle();
  endtask

  task automatic test_reset_mid;
    int busy_cnt, ts_cnt;
    busy_cnt = 0; ts_cnt = 0;
    bus.call = 1'b1;
    repeat (2) tick();
    bus.call = 1'b0;
    repeat (15) tick();
    n_vec++; if (bus.busy !== 1'b1 || bus.blink_on !== 1'b0 || bus.pend_cnt !== 2'd1) begin
      n_err++; $display("FAIL rstmid_pre: busy=%b blink=%b pend=%0d want 1 0 1", bus.busy, bus.blink_on, bus.pend_cnt); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy: got %b want 0", bus.busy); end
    n_vec++; if (bus.timer_start !== 1'b0) begin n_err++; $display("FAIL rstmid_ts: got %b want 0", bus.timer_start); end
    n_vec++; if (bus.blink_on !== 1'b0) begin n_err++; $display("FAIL rstmid_blink: got %b want 0", bus.blink_on); end
    n_vec++; if (bus.pend_cnt !== 2'd0) begin n_err++; $display("FAIL rstmid_pend: got %0d want 0", bus.pend_cnt); end
    n_vec++; if (bus.overflow !== 1'b0) begin n_err++; $display("FAIL rstmid_ovf: got %b want 0", bus.overflow); end
    for (int i = 0; i < 10; i++) begin
      busy_cnt += int'(bus.busy);
      ts_cnt += int'(bus.timer_start);
      tick();
    end
    n_vec++; if (busy_cnt != 0 || ts_cnt != 0) begin
      n_err++; $display("FAIL rstmid_stale: busy_cycles=%0d ts=%0d want 0 0", busy_cnt, ts_cnt); end
    wait_idle();
  endtask

`ifdef CALL_BLINK_CANCEL_EN
  task automatic test_cancel;
    int busy_cnt;
    busy_cnt = 0;
    bus.call = 1'b1;
    repeat (3) tick();
    bus.call = 1'b0;
    n_vec++; if (bus.pend_cnt !== 2'd2 || bus.blink_on !== 1'b1) begin
      n_err++; $display("FAIL cancel_pre: pend=%0d blink=%b want 2 1", bus.pend_cnt, bus.blink_on); end
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL cancel_busy: got %b want 0", bus.busy); end
    n_vec++; if (bus.blink_on !== 1'b0) begin n_err++; $display("FAIL cancel_blink: got %b want 0", bus.blink_on); end
    n_vec++; if (bus.pend_cnt !== 2'd0) begin n_err++; $display("FAIL cancel_pend: got %0d want 0", bus.pend_cnt); end
    n_vec++; if (bus.timer_start !== 1'b0) begin n_err++; $display("FAIL cancel_ts: got %b want 0", bus.timer_start); end
    for (int i = 0; i < 10; i++) begin
      busy_cnt += int'(bus.busy);
      tick();
    end
    n_vec++; if (busy_cnt != 0) begin n_err++; $display("FAIL cancel_stale: busy_cycles=%0d want 0", busy_cnt); end
    wait_idle();
  endtask
`endif

  initial begin
    bus.call = 1'b0;
    test_reset();
    test_idle_done();
    test_single();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
`ifdef CALL_BLINK_CANCEL_EN
    test_cancel();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, vectors=%0d miscompares=%0d", n_vec, n_err);
    $fatal(1, "timeout");
  end

endmodule
